instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetch/issue controller for the bit-serial core.
- Holds the program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Latches each instruction into the instruction register driving the core's opcode/instr inputs, then issues a one-cycle start pulse (replaces the manual button edge) and waits for the core's completion pulse.
- Supports free-run and single-step modes, a HALT opcode, PC load and a fetch-timeout fault.

Parameters:
- PC_W, 8, program counter / imem address width
- CNT_W, 16, retired-instruction counter width
- FETCH_TIMEOUT, 64, max FETCH cycles without ack before fault; 0 disables the timeout
- HALT_OPCODE, 4'b1111, opcode the sequencer consumes as HALT; never issued to the core

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- run  in  1  level; continuous execution while high
- step  in  1  one-cycle pulse; execute exactly one instruction
- halt_clr  in  1  pulse; leave HALTED, clear fault
- pc_load  in  1  pulse; load PC (honoured only in IDLE/HALTED)
- pc_load_val  in  PC_W  value for pc_load
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  one-cycle ack; imem_rdata valid this cycle
- imem_rdata  in  16  fetched instruction
- instr_q  out  16  instruction register; [3:0] = opcode, [15:4] = instr to core
- start  out  1  one-cycle start pulse to core
- exec_done  in  1  one-cycle pulse from core when its write-back completes
- pc  out  PC_W  current program counter
- retired  out  CNT_W  retired instruction count (wraps)
- busy  out  1  high in any state other than IDLE/HALTED
- halted  out  1  high in HALTED
- fault  out  1  sticky fetch-timeout flag

Behaviour:
- Reset (async, rstn low) → state IDLE. Outputs: pc=0, instr_q=0, retired=0, imem_req=0, start=0, busy=0, halted=0, fault=0, single-step flag=0.
- Reset mid-operation aborts any fetch or execution immediately.
- All outputs are Moore, decoded from the state register or held in flops; no combinational input→output paths.
- States: IDLE, FETCH, ISSUE, WAIT, ADVANCE, HALTED.
- IDLE:
  - pc_load → pc <= pc_load_val; no state change that cycle (load beats run/step).
  - Else run → FETCH with sstep=0.
  - Else step → FETCH with sstep=1.
  - run and step together: run wins.
- FETCH:
  - imem_req=1, imem_addr=pc; timeout counter cleared on entry.
  - imem_ack → instr_q <= imem_rdata.
    - If imem_rdata[3:0]==HALT_OPCODE → HALTED (pc unchanged, retired unchanged).
    - Else → ISSUE.
  - No ack for FETCH_TIMEOUT consecutive cycles → HALTED with fault=1.
  - Ack on the final timeout cycle wins (no fault).
  - run dropping during FETCH does not abort.
- ISSUE: start=1 for exactly one cycle → WAIT.
- WAIT: hold instr_q stable. exec_done → ADVANCE. exec_done outside WAIT is ignored.
- ADVANCE:
  - pc <= pc+1 modulo 2^PC_W (all-ones wraps to 0).
  - retired <= retired+1 (wraps).
  - Then → FETCH if run && !sstep, else → IDLE.
- HALTED:
  - halt_clr → IDLE, fault <= 0.
  - pc_load honoured; pc_load and halt_clr in the same cycle both take effect.
  - run/step ignored.
- Latency: run high in IDLE at cycle 0 → imem_req cycle 1. Ack in cycle 1 → start cycle 2. exec_done in cycle n → pc increments in cycle n+1 → next imem_req in cycle n+2.

Optional Feature:
- Macro: SEQ_BREAKPOINT_EN.
- When defined:
  - Added ports: bp_valid (in, 1), bp_addr (in, PC_W), bp_hit (out, 1, sticky, reset 0, cleared by halt_clr).
  - On the ADVANCE→FETCH transition, if bp_valid && new pc==bp_addr → go to HALTED with bp_hit=1 instead of FETCH.
  - The check applies only on ADVANCE→FETCH, so the first fetch after IDLE/HALTED never breaks and resume proceeds past the breakpoint.
- When undefined: the three ports are absent and behaviour is exactly as above.

Decomposition:
- Package seq_pkg:
  - state enum localparams (6 states, 3-bit)
  - HALT_OPCODE default
  - INSTR_W=16
  - OPCODE field slice constants [3:0] / [15:4]
- One sub-module: seq_timeout_ctr. It takes clear, enable and an expire output, and is tied to FETCH_TIMEOUT (0 ⇒ expire never asserts).

Test Plan:
- Reset, run=1, imem returns ADD (opcode 0000) at addr 0 with ack in 1st FETCH cycle → start in cycle 2. Assert exec_done 10 cycles later → pc=1, retired=1, imem_req next-but-one cycle.
- step pulse with run=0, program ADD, XOR → exactly one start, then IDLE with pc=1. Second step → pc=2, retired=2.
- run=1, instr at addr 3 = 16'h000F (HALT) → halted=1, pc=3, no start pulse, retired=3. halt_clr → IDLE.
- Withhold imem_ack with FETCH_TIMEOUT=4 → fault=1, halted=1 after 4 FETCH cycles. Ack on the 4th cycle instead → no fault, ISSUE.
- PC_W=8, pc_load 8'hFF in IDLE, then step → fetch 0xFF, pc wraps to 0x00 after exec_done. pc_load simultaneous with run → pc loaded, fetch starts the following cycle.
- With SEQ_BREAKPOINT_EN, bp_addr=2, run from 0 → halts with pc=2, bp_hit=1, retired=2. halt_clr + run → fetches addr 2 and continues.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
//   - seq_state_e : sequencer FSM state encoding (3 bits, 6 states)
//   - INSTR_W     : fetched instruction width
//   - OPC_* / INSTR_* : bit positions of the opcode and the core-instruction field
//   - HALT_OPCODE_DEF : default opcode consumed as HALT
package seq_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned OPC_LSB   = 0;
    localparam int unsigned OPC_MSB   = 3;
    localparam int unsigned INSTR_LSB = 4;
    localparam int unsigned INSTR_MSB = 15;

    localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_HALTED  = 3'd5
    } seq_state_e;

    // Opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    // Field handed to the core as its instr operand.
    function automatic logic [INSTR_MSB-INSTR_LSB:0] core_field_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_MSB:INSTR_LSB];
    endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Fetch watchdog: counts consecutive enabled cycles and flags the last allowed one.
//   clk, rstn : clock, async active-low reset
//   clear     : synchronous clear of the count
//   enable    : count this cycle
//   expire    : high during the TIMEOUT-th consecutive enabled cycle (never when TIMEOUT==0)
module seq_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_ok;
            assign unused_ok = ^{clk, rstn, clear, enable};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [CW-1:0] cnt;

            // Count enabled cycles; first enabled cycle sees cnt==0.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && !expire) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign expire = enable && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue controller for the bit-serial core.
// Fetches 16-bit instructions over a req/ack handshake, latches them into
// instr_q, pulses start and waits for exec_done, then advances the PC.
//   run/step/halt_clr/pc_load(+pc_load_val) : control inputs
//   imem_req/imem_addr/imem_ack/imem_rdata  : instruction memory handshake
//   instr_q/start/exec_done                 : core interface
//   pc/retired/busy/halted/fault            : status
// Optional build macro SEQ_BREAKPOINT_EN adds bp_valid, bp_addr, bp_hit:
// a PC breakpoint checked only when advancing straight into the next fetch.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned      PC_W          = 8,
    parameter int unsigned      CNT_W         = 16,
    parameter int unsigned      FETCH_TIMEOUT = 64,
    parameter logic [OPC_W-1:0] HALT_OPCODE   = HALT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic               step,
    input  logic               halt_clr,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_load_val,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_q,
    output logic               start,
    input  logic               exec_done,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   retired,
    output logic               busy,
    output logic               halted,
`ifdef SEQ_BREAKPOINT_EN
    input  logic               bp_valid,
    input  logic [PC_W-1:0]    bp_addr,
    output logic               bp_hit,
`endif
    output logic               fault
);

    seq_state_e         state;
    seq_state_e         state_d;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] instr_d;
    logic [CNT_W-1:0]   retired_d;
    logic               sstep;
    logic               sstep_d;
    logic               fault_d;
    logic               expire;
    logic               bp_match;
`ifdef SEQ_BREAKPOINT_EN
    logic               bp_hit_d;

    // pc already holds the incremented value while in ADVANCE.
    assign bp_match = bp_valid && (pc == bp_addr);
`else
    assign bp_match = 1'b0;
`endif

    assign imem_addr = pc;

    seq_timeout_ctr #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (state != S_FETCH),
        .enable (state == S_FETCH),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        instr_d   = instr_q;
        retired_d = retired;
        sstep_d   = sstep;
        fault_d   = fault;
`ifdef SEQ_BREAKPOINT_EN
        bp_hit_d  = bp_hit;
`endif
        case (state)
            S_IDLE: begin
                if (pc_load) begin
                    pc_d = pc_load_val;
                end else if (run) begin
                    state_d = S_FETCH;
                    sstep_d = 1'b0;
                end else if (step) begin
                    state_d = S_FETCH;
                    sstep_d = 1'b1;
                end
            end
            S_FETCH: begin
                // An ack in the last allowed cycle beats the timeout.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = (opcode_of(imem_rdata) == HALT_OPCODE) ? S_HALTED : S_ISSUE;
                end else if (expire) begin
                    state_d = S_HALTED;
                    fault_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Retire on entry to ADVANCE so the new pc is visible there.
                if (exec_done) begin
                    state_d   = S_ADVANCE;
                    pc_d      = pc + PC_W'(1);
                    retired_d = retired + CNT_W'(1);
                end
            end
            S_ADVANCE: begin
                if (run && !sstep) begin
                    if (bp_match) begin
                        state_d  = S_HALTED;
`ifdef SEQ_BREAKPOINT_EN
                        bp_hit_d = 1'b1;
`endif
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                if (halt_clr) begin
                    state_d  = S_IDLE;
                    fault_d  = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end
                if (pc_load) begin
                    pc_d = pc_load_val;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers and Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc       <= '0;
            instr_q  <= '0;
            retired  <= '0;
            sstep    <= 1'b0;
            fault    <= 1'b0;
            imem_req <= 1'b0;
            start    <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
            bp_hit   <= 1'b0;
`endif
        end else begin
            pc       <= pc_d;
            instr_q  <= instr_d;
            retired  <= retired_d;
            sstep    <= sstep_d;
            fault    <= fault_d;
            imem_req <= (state_d == S_FETCH);
            start    <= (state_d == S_ISSUE);
            busy     <= (state_d != S_IDLE) && (state_d != S_HALTED);
            halted   <= (state_d == S_HALTED);
`ifdef SEQ_BREAKPOINT_EN
            bp_hit   <= bp_hit_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: small imem/core responders plus
// hand-computed expectations for run, step, HALT, timeout, PC wrap/load and
// (with SEQ_BREAKPOINT_EN) breakpoints.
module tb_instr_sequencer;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              run;
    logic              step;
    logic              halt_clr;
    logic              pc_load;
    logic [PC_W-1:0]   pc_load_val;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic [15:0]       instr_q;
    logic              start;
    logic              exec_done;
    logic [PC_W-1:0]   pc;
    logic [CNT_W-1:0]  retired;
    logic              busy;
    logic              halted;
    logic              fault;
`ifdef SEQ_BREAKPOINT_EN
    logic              bp_valid;
    logic [PC_W-1:0]   bp_addr;
    logic              bp_hit;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [256];
    int ack_delay = 1;
    int exec_lat  = 2;
    int fetch_cyc = 0;
    int exec_cnt  = 0;
    int start_cnt = 0;
    int s0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W          (PC_W),
        .CNT_W         (CNT_W),
        .FETCH_TIMEOUT (4),
        .HALT_OPCODE   (4'b1111)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .run         (run),
        .step        (step),
        .halt_clr    (halt_clr),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_q     (instr_q),
        .start       (start),
        .exec_done   (exec_done),
        .pc          (pc),
        .retired     (retired),
        .busy        (busy),
        .halted      (halted),
`ifdef SEQ_BREAKPOINT_EN
        .bp_valid    (bp_valid),
        .bp_addr     (bp_addr),
        .bp_hit      (bp_hit),
`endif
        .fault       (fault)
    );

    // imem acks in the ack_delay-th FETCH cycle (0 = never); core pulses
    // exec_done exec_lat cycles after start.
    always @(negedge clk) begin
        if (!rstn) begin
            imem_ack  = 1'b0;
            exec_done = 1'b0;
            exec_cnt  = 0;
            fetch_cyc = 0;
        end else begin
            if (imem_req) begin
                fetch_cyc = fetch_cyc + 1;
                if (fetch_cyc == ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                end else begin
                    imem_ack = 1'b0;
                end
            end else begin
                fetch_cyc = 0;
                imem_ack  = 1'b0;
            end
            exec_done = 1'b0;
            if (exec_cnt != 0) begin
                exec_cnt = exec_cnt - 1;
                if (exec_cnt == 0) exec_done = 1'b1;
            end
            if (start) begin
                start_cnt = start_cnt + 1;
                exec_cnt  = exec_lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        halt_clr    = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
`ifdef SEQ_BREAKPOINT_EN
        bp_valid    = 1'b0;
        bp_addr     = '0;
`endif
        cyc(2);
        rstn = 1'b1;
        cyc(1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            cyc(1);
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic wait_halted(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (halted) break;
            cyc(1);
        end
        chk(tag, 32'(halted), 1);
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (start) break;
            cyc(1);
        end
        chk(tag, 32'(start), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h0010;  // ADD
        mem[1]   = 16'h0023;  // XOR
        mem[2]   = 16'h0031;
        mem[3]   = 16'h000F;  // HALT
        mem[5]   = 16'h0054;
        mem[255] = 16'h0ABC;
        imem_rdata = 16'h0000;

        // Reset state
        do_reset();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_instr", 32'(instr_q), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_flags", 32'({start, busy, halted, fault}), 0);

        // Free-run latency: req in cycle 1, start in cycle 2, exec_done 10 later
        exec_lat = 10;
        s0 = start_cnt;
        run = 1'b1;
        cyc(1);
        chk("t1_req", 32'(imem_req), 1);
        chk("t1_addr", 32'(imem_addr), 0);
        cyc(1);
        chk("t1_start", 32'(start), 1);
        cyc(10);
        chk("t1_pc_wait", 32'(pc), 0);
        chk("t1_busy", 32'(busy), 1);
        cyc(1);
        chk("t1_req_adv", 32'(imem_req), 0);
        cyc(1);
        chk("t1_req_next", 32'(imem_req), 1);
        chk("t1_addr_next", 32'(imem_addr), 1);
        chk("t1_retired", 32'(retired), 1);
        chk("t1_starts", 32'(start_cnt - s0), 1);
        run = 1'b0;
        exec_lat = 2;
        wait_idle("t1_idle");
        chk("t1_pc_end", 32'(pc), 2);
        chk("t1_ret_end", 32'(retired), 2);
        chk("t1_instr_end", 32'(instr_q), 'h0023);

        // Reset mid-execution aborts immediately
        run = 1'b1;
        wait_start("t1b_start");
        cyc(1);
        rstn = 1'b0;
        run  = 1'b0;
        #1;
        chk("t1b_busy", 32'(busy), 0);
        chk("t1b_pc", 32'(pc), 0);
        chk("t1b_retired", 32'(retired), 0);
        chk("t1b_instr", 32'(instr_q), 0);
        cyc(2);
        rstn = 1'b1;
        cyc(1);

        // Single-step
        s0 = start_cnt;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        wait_idle("t2_idle1");
        chk("t2_starts1", 32'(start_cnt - s0), 1);
        chk("t2_pc1", 32'(pc), 1);
        chk("t2_ret1", 32'(retired), 1);
        chk("t2_instr1", 32'(instr_q), 'h0010);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        wait_idle("t2_idle2");
        chk("t2_pc2", 32'(pc), 2);
        chk("t2_ret2", 32'(retired), 2);
        chk("t2_instr2", 32'(instr_q), 'h0023);

        // HALT opcode at addr 3
        do_reset();
        s0 = start_cnt;
        run = 1'b1;
        wait_halted("t3_halt");
        chk("t3_pc", 32'(pc), 3);
        chk("t3_retired", 32'(retired), 3);
        chk("t3_instr", 32'(instr_q), 'h000F);
        chk("t3_fault", 32'(fault), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_starts", 32'(start_cnt - s0), 3);
        cyc(3);
        chk("t3_run_ignored", 32'(halted), 1);
        chk("t3_starts_hold", 32'(start_cnt - s0), 3);
        run         = 1'b0;
        halt_clr    = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 8'h00;
        cyc(1);
        halt_clr = 1'b0;
        pc_load  = 1'b0;
        chk("t3_clr_halted", 32'(halted), 0);
        chk("t3_clr_busy", 32'(busy), 0);
        chk("t3_clr_pc", 32'(pc), 0);

        // Fetch timeout (4 cycles) and ack on the final cycle
        pc_load     = 1'b1;
        pc_load_val = 8'h05;
        cyc(1);
        pc_load = 1'b0;
        chk("t4_load", 32'(pc), 5);
        ack_delay = 0;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(3);
        chk("t4_req4", 32'(imem_req), 1);
        chk("t4_nofault4", 32'(fault), 0);
        cyc(1);
        chk("t4_fault", 32'(fault), 1);
        chk("t4_halted", 32'(halted), 1);
        chk("t4_req_off", 32'(imem_req), 0);
        chk("t4_pc", 32'(pc), 5);
        halt_clr = 1'b1;
        cyc(1);
        halt_clr = 1'b0;
        chk("t4_fault_clr", 32'(fault), 0);
        chk("t4_halt_clr", 32'(halted), 0);
        ack_delay = 4;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(3);
        chk("t4_req_last", 32'(imem_req), 1);
        cyc(1);
        chk("t4_late_start", 32'(start), 1);
        chk("t4_late_fault", 32'(fault), 0);
        chk("t4_late_halted", 32'(halted), 0);
        ack_delay = 1;
        wait_idle("t4_idle");
        chk("t4_pc_end", 32'(pc), 6);
        chk("t4_ret_end", 32'(retired), 4);
        chk("t4_instr_end", 32'(instr_q), 'h0054);

        // PC wrap from 0xFF, then pc_load together with run
        pc_load     = 1'b1;
        pc_load_val = 8'hFF;
        cyc(1);
        pc_load = 1'b0;
        chk("t5_load_ff", 32'(pc), 'hFF);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("t5_addr_ff", 32'(imem_addr), 'hFF);
        wait_idle("t5_idle");
        chk("t5_wrap", 32'(pc), 0);
        chk("t5_ret", 32'(retired), 5);
        chk("t5_instr", 32'(instr_q), 'h0ABC);
        pc_load     = 1'b1;
        pc_load_val = 8'h01;
        run         = 1'b1;
        cyc(1);
        pc_load = 1'b0;
        chk("t5_load_run_pc", 32'(pc), 1);
        chk("t5_load_run_req", 32'(imem_req), 0);
        cyc(1);
        chk("t5_fetch_req", 32'(imem_req), 1);
        chk("t5_fetch_addr", 32'(imem_addr), 1);
        run = 1'b0;
        wait_idle("t5_idle2");
        chk("t5_pc_end", 32'(pc), 2);
        chk("t5_ret_end", 32'(retired), 6);

`ifdef SEQ_BREAKPOINT_EN
        // Breakpoint at addr 2, then resume past it
        do_reset();
        bp_valid = 1'b1;
        bp_addr  = 8'h02;
        run      = 1'b1;
        wait_halted("t6_halt");
        chk("t6_pc", 32'(pc), 2);
        chk("t6_bp_hit", 32'(bp_hit), 1);
        chk("t6_retired", 32'(retired), 2);
        chk("t6_fault", 32'(fault), 0);
        halt_clr = 1'b1;
        cyc(1);
        halt_clr = 1'b0;
        chk("t6_bp_clr", 32'(bp_hit), 0);
        chk("t6_halt_clr", 32'(halted), 0);
        cyc(1);
        chk("t6_resume_req", 32'(imem_req), 1);
        chk("t6_resume_addr", 32'(imem_addr), 2);
        wait_halted("t6_halt2");
        chk("t6_pc2", 32'(pc), 3);
        chk("t6_ret2", 32'(retired), 3);
        chk("t6_bp_hit2", 32'(bp_hit), 0);
        run = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
